// File: rtl/relay_bank_pkg.sv
// Shared types and helpers for the relay bank: channel state encoding,
// ramp counter sizing and conductance level scaling.
package relay_bank_pkg;

    typedef enum logic [1:0] {
        OFF       = 2'd0,
        RAMP_UP   = 2'd1,
        ON        = 2'd2,
        RAMP_DOWN = 2'd3
    } relay_state_t;

    function automatic int cnt_width(input int ramp_cyc);
        return $clog2(ramp_cyc + 1);
    endfunction

    // Linear map of ramp step onto 0 .. 2^gw-1; step==ramp_cyc gives all-ones exactly.
    function automatic int scale_level(input int cnt, input int gw, input int ramp_cyc);
        return (cnt * ((1 << gw) - 1)) / ramp_cyc;
    endfunction

endpackage

// File: rtl/relay_channel.sv
// One hysteretic relay: registered threshold compare, override hold,
// four-state ramp FSM and registered conductance level.
module relay_channel
    import relay_bank_pkg::*;
#(
    parameter int CW       = 16,
    parameter int VT       = 0,
    parameter int VH       = 256,
    parameter int GW       = 8,
    parameter int RAMP_CYC = 16,
    parameter bit INIT_ON  = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ctrl_valid,
    input  logic signed [CW-1:0] ctrl,
    input  logic                 frc_wr,
    input  logic                 frc_on,
    input  logic                 frc_release,
    output logic [GW-1:0]        g_level,
    output logic                 is_on,
    output logic                 busy
);

    localparam int CNTW = cnt_width(RAMP_CYC);
    localparam logic [CNTW-1:0] RAMP_MAX = CNTW'(RAMP_CYC);
    localparam logic signed [CW:0] HI = (CW+1)'(VT + VH);
    localparam logic signed [CW:0] LO = (CW+1)'(VT - VH);

    logic signed [CW:0] ctrl_x;
    logic               tgt, ovr_act, ovr_val, eff;
    relay_state_t       state, state_nxt;
    logic [CNTW-1:0]    cnt, cnt_nxt;

    // One extra bit so VT+/-VH can never wrap against a full-scale sample.
    assign ctrl_x = {ctrl[CW-1], ctrl};

    always_ff @(posedge clk) begin
        if (rst) begin
            tgt <= INIT_ON;
        end else if (ctrl_valid) begin
            if (ctrl_x > HI)      tgt <= 1'b1;
            else if (ctrl_x < LO) tgt <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovr_act <= 1'b0;
            ovr_val <= 1'b0;
        end else if (frc_wr) begin
            ovr_act <= ~frc_release;
            ovr_val <= frc_on;
        end
    end

    // A write arriving this cycle steers the FSM immediately.
    always_comb begin
        eff = ovr_act ? ovr_val : tgt;
        if (frc_wr) eff = frc_release ? tgt : frc_on;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            OFF: begin
                if (eff) begin
                    cnt_nxt   = cnt + 1'b1;
                    state_nxt = (cnt_nxt == RAMP_MAX) ? ON : RAMP_UP;
                end
            end
            ON: begin
                if (!eff) begin
                    cnt_nxt   = cnt - 1'b1;
                    state_nxt = (cnt_nxt == '0) ? OFF : RAMP_DOWN;
                end
            end
            RAMP_UP, RAMP_DOWN: begin
                if (eff) begin
                    cnt_nxt   = cnt + 1'b1;
                    state_nxt = (cnt_nxt == RAMP_MAX) ? ON : RAMP_UP;
                end else begin
                    cnt_nxt   = cnt - 1'b1;
                    state_nxt = (cnt_nxt == '0) ? OFF : RAMP_DOWN;
                end
            end
            default: begin
                state_nxt = OFF;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= INIT_ON ? ON : OFF;
            cnt     <= INIT_ON ? RAMP_MAX : '0;
            g_level <= INIT_ON ? '1 : '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            g_level <= GW'(scale_level(int'(cnt_nxt), GW, RAMP_CYC));
        end
    end

    assign is_on = (state == ON);
    assign busy  = (state == RAMP_UP) || (state == RAMP_DOWN);

endmodule

// File: rtl/relay_bank.sv
// Bank of CHANNELS ramped hysteretic relays with a single-entry host
// override holding register in front of the per-channel logic.
module relay_bank
    import relay_bank_pkg::*;
#(
    parameter int                  CHANNELS = 4,
    parameter int                  CW       = 16,
    parameter int                  VT       = 0,
    parameter int                  VH       = 256,
    parameter int                  GW       = 8,
    parameter int                  RAMP_CYC = 16,
    parameter logic [CHANNELS-1:0] INIT_ON  = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ctrl_valid,
    input  logic [CHANNELS*CW-1:0] ctrl,
    input  logic                   frc_valid,
    output logic                   frc_ready,
    input  logic [3:0]             frc_ch,
    input  logic                   frc_on,
    input  logic                   frc_release,
    output logic [CHANNELS*GW-1:0] g_level,
    output logic [CHANNELS-1:0]    is_on,
    output logic [CHANNELS-1:0]    busy
);

    logic       pend, pon, prel;
    logic [3:0] pch;

    assign frc_ready = ~pend;

    // Accepted request is held for exactly one cycle while it is applied.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= 1'b0;
            pch  <= '0;
            pon  <= 1'b0;
            prel <= 1'b0;
        end else begin
            pend <= frc_valid & frc_ready;
            if (frc_valid && frc_ready) begin
                pch  <= frc_ch;
                pon  <= frc_on;
                prel <= frc_release;
            end
        end
    end

    // Out-of-range channel numbers match no instance and fall through.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        relay_channel #(
            .CW       (CW),
            .VT       (VT),
            .VH       (VH),
            .GW       (GW),
            .RAMP_CYC (RAMP_CYC),
            .INIT_ON  (INIT_ON[c])
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .ctrl_valid  (ctrl_valid),
            .ctrl        (ctrl[c*CW +: CW]),
            .frc_wr      (pend && (pch == 4'(c))),
            .frc_on      (pon),
            .frc_release (prel),
            .g_level     (g_level[c*GW +: GW]),
            .is_on       (is_on[c]),
            .busy        (busy[c])
        );
    end

endmodule

// File: tb/tb_relay_bank.sv
// Randomized and directed bench for relay_bank against a per-channel
// ramp-position model derived from the threshold and override rules.
module tb_relay_bank;

    localparam int CH = 4;
    localparam int CW = 16;
    localparam int GW = 8;
    localparam int R  = 16;
    localparam int VT = 0;
    localparam int VH = 256;
    localparam logic [CH-1:0] INIT = 4'b0101;
    localparam int VW = CH*GW + 2*CH + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ctrl_valid = 1'b0;
    logic [CH*CW-1:0]  ctrl = '0;
    logic              frc_valid = 1'b0;
    logic              frc_ready;
    logic [3:0]        frc_ch = '0;
    logic              frc_on = 1'b0;
    logic              frc_release = 1'b0;
    logic [CH*GW-1:0]  g_level;
    logic [CH-1:0]     is_on, busy;

    int tests = 0;
    int fails = 0;

    // model: ramp position per channel plus latched targets / overrides
    int m_cnt[CH];
    bit m_tgt[CH], m_oa[CH], m_ov[CH];
    bit m_pend, m_pon, m_prel;
    int m_pch;

    relay_bank #(
        .CHANNELS(CH), .CW(CW), .VT(VT), .VH(VH), .GW(GW), .RAMP_CYC(R), .INIT_ON(INIT)
    ) dut (
        .clk(clk), .rst(rst), .ctrl_valid(ctrl_valid), .ctrl(ctrl),
        .frc_valid(frc_valid), .frc_ready(frc_ready), .frc_ch(frc_ch),
        .frc_on(frc_on), .frc_release(frc_release),
        .g_level(g_level), .is_on(is_on), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic model_clock();
        if (rst) begin
            for (int c = 0; c < CH; c++) begin
                m_cnt[c] = INIT[c] ? R : 0;
                m_tgt[c] = INIT[c];
                m_oa[c]  = 0;
                m_ov[c]  = 0;
            end
            m_pend = 0; m_pon = 0; m_prel = 0; m_pch = 0;
        end else begin
            for (int c = 0; c < CH; c++) begin
                bit e;
                int v;
                if (m_pend && m_pch == c) e = m_prel ? m_tgt[c] : m_pon;
                else                      e = m_oa[c] ? m_ov[c] : m_tgt[c];
                if (e && m_cnt[c] < R)       m_cnt[c]++;
                else if (!e && m_cnt[c] > 0) m_cnt[c]--;
                if (m_pend && m_pch == c) begin
                    m_oa[c] = !m_prel;
                    m_ov[c] = m_pon;
                end
                v = $signed(ctrl[c*CW +: CW]);
                if (ctrl_valid) begin
                    if (v > VT + VH)      m_tgt[c] = 1;
                    else if (v < VT - VH) m_tgt[c] = 0;
                end
            end
            if (frc_valid && !m_pend) begin
                m_pch = int'(frc_ch); m_pon = frc_on; m_prel = frc_release;
                m_pend = 1;
            end else begin
                m_pend = 0;
            end
        end
    endtask

    function automatic logic [VW-1:0] exp_vec();
        logic [CH*GW-1:0] g;
        logic [CH-1:0] on, bz;
        for (int c = 0; c < CH; c++) begin
            g[c*GW +: GW] = GW'(m_cnt[c] * ((1 << GW) - 1) / R);
            on[c] = (m_cnt[c] == R);
            bz[c] = (m_cnt[c] > 0) && (m_cnt[c] < R);
        end
        return {g, on, bz, !m_pend};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic set_ctrl(input int c, input int v);
        ctrl[c*CW +: CW] = CW'(v);
    endtask

    function automatic int gl(input int c);
        return int'(g_level[c*GW +: GW]);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        tests++;
        if (g_level !== 32'h00FF00FF || busy !== 4'b0 || frc_ready !== 1'b1 || is_on !== 4'b0101) begin
            fails++;
            $display("FAIL reset: g=%h busy=%b rdy=%b on=%b want g=00ff00ff busy=0000 rdy=1 on=0101",
                     g_level, busy, frc_ready, is_on);
        end
        rst = 1'b0;
    endtask

    task automatic test_ramp_up();
        ctrl_valid = 1'b1;
        set_ctrl(0, -300);
        for (int i = 0; i < 20; i++) tick();
        set_ctrl(0, 0);   tick();
        set_ctrl(0, 300); tick();
        tests++;
        if (busy[0] !== 1'b0) begin
            fails++; $display("FAIL ramp_lat1: busy0=%b want 0", busy[0]);
        end
        tick();
        tests++;
        if (busy[0] !== 1'b1 || gl(0) != 15) begin
            fails++; $display("FAIL ramp_lat2: busy0=%b g0=%0d want 1/15", busy[0], gl(0));
        end
        for (int i = 0; i < 15; i++) begin
            tick();
            tests++;
            if ({g_level, is_on, busy, frc_ready} !== exp_vec()) begin
                fails++; $display("FAIL ramp_up[%0d]: got %h want %h", i, {g_level, is_on, busy, frc_ready}, exp_vec());
            end
        end
        tests++;
        if (gl(0) != 255 || is_on[0] !== 1'b1 || busy[0] !== 1'b0) begin
            fails++; $display("FAIL ramp_end: g0=%0d on=%b busy=%b want 255/1/0", gl(0), is_on[0], busy[0]);
        end
    endtask

    task automatic test_band();
        set_ctrl(0, 200);  for (int i = 0; i < 5; i++) tick();
        set_ctrl(0, -200); for (int i = 0; i < 5; i++) tick();
        set_ctrl(0, 256);  tick();
        set_ctrl(0, -256); for (int i = 0; i < 5; i++) tick();
        tests++;
        if (is_on[0] !== 1'b1 || busy[0] !== 1'b0 || gl(0) != 255) begin
            fails++; $display("FAIL band_hold: on=%b busy=%b g0=%0d want 1/0/255", is_on[0], busy[0], gl(0));
        end
        set_ctrl(0, -300);
        for (int i = 0; i < 18; i++) begin
            tick();
            tests++;
            if ({g_level, is_on, busy, frc_ready} !== exp_vec()) begin
                fails++; $display("FAIL band_down[%0d]: got %h want %h", i, {g_level, is_on, busy, frc_ready}, exp_vec());
            end
        end
        tests++;
        if (gl(0) != 0 || is_on[0] !== 1'b0 || busy[0] !== 1'b0) begin
            fails++; $display("FAIL band_off: g0=%0d on=%b busy=%b want 0/0/0", gl(0), is_on[0], busy[0]);
        end
    endtask

    task automatic test_reverse();
        int prev;
        int guard;
        set_ctrl(0, 300);
        guard = 0;
        while (m_cnt[0] != 8 && guard < 40) begin tick(); guard++; end
        tests++;
        if (guard >= 40 || gl(0) != 127) begin
            fails++; $display("FAIL rev_step8: g0=%0d want 127 (guard %0d)", gl(0), guard);
        end
        set_ctrl(0, -300);
        prev = gl(0);
        for (int i = 0; i < 14; i++) begin
            tick();
            tests++;
            if ({g_level, is_on, busy, frc_ready} !== exp_vec() || (gl(0) - prev) > 16 || (prev - gl(0)) > 16) begin
                fails++; $display("FAIL reverse[%0d]: got %h want %h prev g0=%0d", i, {g_level, is_on, busy, frc_ready}, exp_vec(), prev);
            end
            prev = gl(0);
        end
        tests++;
        if (gl(0) != 0 || busy[0] !== 1'b0) begin
            fails++; $display("FAIL rev_end: g0=%0d busy=%b want 0/0", gl(0), busy[0]);
        end
    endtask

    task automatic send_frc(input int ch, input bit on, input bit rel);
        frc_ch = 4'(ch); frc_on = on; frc_release = rel; frc_valid = 1'b1;
        tick();
        tests++;
        if (frc_ready !== 1'b0) begin
            fails++; $display("FAIL frc_ready_low: rdy=%b want 0", frc_ready);
        end
        frc_valid = 1'b0;
    endtask

    task automatic test_override();
        set_ctrl(1, -1000);
        tick(); tick();
        send_frc(1, 1'b1, 1'b0);
        for (int i = 0; i < 18; i++) begin
            tick();
            tests++;
            if ({g_level, is_on, busy, frc_ready} !== exp_vec()) begin
                fails++; $display("FAIL frc_on[%0d]: got %h want %h", i, {g_level, is_on, busy, frc_ready}, exp_vec());
            end
        end
        tests++;
        if (is_on[1] !== 1'b1 || gl(1) != 255 || frc_ready !== 1'b1) begin
            fails++; $display("FAIL frc_on_end: on1=%b g1=%0d rdy=%b want 1/255/1", is_on[1], gl(1), frc_ready);
        end
        send_frc(1, 1'b1, 1'b1);
        for (int i = 0; i < 18; i++) tick();
        tests++;
        if (is_on[1] !== 1'b0 || gl(1) != 0) begin
            fails++; $display("FAIL frc_release: on1=%b g1=%0d want 0/0", is_on[1], gl(1));
        end
        send_frc(15, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        tests++;
        if ({g_level, is_on, busy, frc_ready} !== exp_vec() || busy !== 4'b0) begin
            fails++; $display("FAIL frc_ch15: got %h want %h", {g_level, is_on, busy, frc_ready}, exp_vec());
        end
    endtask

    task automatic test_reset_mid_ramp();
        int guard = 0;
        set_ctrl(1, 300);
        while (m_cnt[1] != 5 && guard < 40) begin tick(); guard++; end
        tests++;
        if (guard >= 40 || busy[1] !== 1'b1) begin
            fails++; $display("FAIL mid_ramp_reach: busy1=%b want 1 (guard %0d)", busy[1], guard);
        end
        rst = 1'b1;
        tick();
        tests++;
        if (g_level !== 32'h00FF00FF || busy !== 4'b0 || frc_ready !== 1'b1 || is_on !== 4'b0101) begin
            fails++; $display("FAIL reset_mid_ramp: g=%h busy=%b rdy=%b on=%b want 00ff00ff/0000/1/0101",
                              g_level, busy, frc_ready, is_on);
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        int pool[8] = '{-300, -257, -256, 0, 256, 257, 300, 0};
        for (int i = 0; i < 600; i++) begin
            ctrl_valid = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 5) == 0) begin
                    if ($urandom_range(0, 7) == 0) set_ctrl(c, int'($urandom_range(0, 65535)) - 32768);
                    else                           set_ctrl(c, pool[$urandom_range(0, 7)]);
                end
            end
            frc_valid   = ($urandom_range(0, 9) == 0);
            frc_ch      = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
            frc_on      = 1'($urandom_range(0, 1));
            frc_release = ($urandom_range(0, 2) == 0);
            tick();
            tests++;
            if ({g_level, is_on, busy, frc_ready} !== exp_vec()) begin
                fails++; $display("FAIL random[%0d]: got %h want %h", i, {g_level, is_on, busy, frc_ready}, exp_vec());
            end
        end
        frc_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_band();
        test_reverse();
        test_override();
        test_reset_mid_ramp();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
